alu_control_unit: RTL and testbench

Fetch/decode/execute sequencer that sits directly upstream of the 8-bit ALU. It fetches 16-bit instructions from program memory and holds a 4×8-bit register file. It drives the ALU's opcode, operands and enable, then writes the 16-bit ALU result back and updates flags. One instruction retires per pass through a multi-cycle state machine; jump, branch and halt are resolved locally.

---
 rtl/cu_pkg.sv | 36 +++
 rtl/alu_control_unit_if.sv | 31 +++
 rtl/cu_regfile.sv | 31 +++
 rtl/alu_control_unit.sv | 169 ++++++++++++++++
 tb/tb_alu_control_unit.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cu_pkg.sv
// Shared opcodes, instruction field positions and FSM state type for the ALU control unit.
package cu_pkg;

    localparam logic [3:0] OP_NOP      = 4'h0;
    localparam logic [3:0] OP_ADD      = 4'h1;
    localparam logic [3:0] OP_SUB      = 4'h2;
    localparam logic [3:0] OP_MUL      = 4'h3;
    localparam logic [3:0] OP_DIV      = 4'h4;
    localparam logic [3:0] OP_ALU_LAST = 4'hA;
    localparam logic [3:0] OP_LDI      = 4'hB;
    localparam logic [3:0] OP_MOV      = 4'hC;
    localparam logic [3:0] OP_JMP      = 4'hD;
    localparam logic [3:0] OP_BRZ      = 4'hE;
    localparam logic [3:0] OP_HALT     = 4'hF;

    localparam int unsigned OPC_MSB = 15;
    localparam int unsigned OPC_LSB = 12;
    localparam int unsigned RD_MSB  = 11;
    localparam int unsigned RD_LSB  = 10;
    localparam int unsigned RS_MSB  = 9;
    localparam int unsigned RS_LSB  = 8;
    localparam int unsigned IMM_MSB = 7;
    localparam int unsigned IMM_LSB = 0;

    localparam int unsigned NUM_REGS = 4;
    localparam int unsigned REG_AW   = $clog2(NUM_REGS);

    typedef enum logic [2:0] {
        StFetch,
        StDecode,
        StExecute,
        StWriteback,
        StHalt
    } state_e;

endpackage

// File: rtl/alu_control_unit_if.sv
// Program-memory, ALU, writeback and status signals of the ALU control unit.
interface alu_control_unit_if;
    logic        instr_req;
    logic [7:0]  instr_addr;
    logic        instr_valid;
    logic [15:0] instr_data;
    logic        alu_enable;
    logic [3:0]  alu_opcode;
    logic [7:0]  alu_operand_1;
    logic [7:0]  alu_operand_2;
    logic [15:0] alu_result;
    logic        wb_valid;
    logic [1:0]  wb_addr;
    logic [7:0]  wb_data;
    logic        flag_zero;
    logic        flag_carry;
    logic        err_div0;
    logic        halted;

    modport master (
        output instr_req, instr_addr, alu_enable, alu_opcode, alu_operand_1, alu_operand_2,
        output wb_valid, wb_addr, wb_data, flag_zero, flag_carry, err_div0, halted,
        input  instr_valid, instr_data, alu_result
    );

    modport slave (
        input  instr_req, instr_addr, alu_enable, alu_opcode, alu_operand_1, alu_operand_2,
        input  wb_valid, wb_addr, wb_data, flag_zero, flag_carry, err_div0, halted,
        output instr_valid, instr_data, alu_result
    );
endinterface

// File: rtl/cu_regfile.sv
// 4x8 register file: two combinational reads, primary + secondary write, async clear.
module cu_regfile
    import cu_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic [REG_AW-1:0] raddr_a,
    output logic [7:0]        rdata_a,
    input  logic [REG_AW-1:0] raddr_b,
    output logic [7:0]        rdata_b,
    input  logic              we_a,
    input  logic [REG_AW-1:0] waddr_a,
    input  logic [7:0]        wdata_a,
    input  logic              we_b,
    input  logic [REG_AW-1:0] waddr_b,
    input  logic [7:0]        wdata_b
);
    logic [7:0] regs_q [NUM_REGS];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= 8'h00;
        end else begin
            if (we_a) regs_q[waddr_a] <= wdata_a;
            if (we_b) regs_q[waddr_b] <= wdata_b;
        end
    end

    assign rdata_a = regs_q[raddr_a];
    assign rdata_b = regs_q[raddr_b];
endmodule

// File: rtl/alu_control_unit.sv
// Fetch/decode/execute/writeback sequencer in front of the 8-bit ALU.
// Optional ALU_DIV_GUARD_EN: DIV by zero skips writeback and sets sticky err_div0.
module alu_control_unit
    import cu_pkg::*;
#(
    parameter logic [7:0] PC_RESET = 8'h00
) (
    input logic                 clk,
    input logic                 reset_n,
    alu_control_unit_if.master  bus
);
    state_e      state_q;
    logic [7:0]  pc_q;
    logic [15:0] instr_q;
    logic        alu_enable_q;
    logic [3:0]  alu_opcode_q;
    logic [7:0]  operand_1_q, operand_2_q;
    logic [7:0]  res_hi_q;
    logic        wb_valid_q, mul_wr_q;
    logic [1:0]  wb_addr_q;
    logic [7:0]  wb_data_q;
    logic        flag_zero_q, flag_carry_q, halted_q;

    logic [3:0]  opc;
    logic [1:0]  rd, rs;
    logic [7:0]  imm;
    logic [7:0]  rdata_rd, rdata_rs;
    logic        ex_wr, ex_mul, ex_carry;
    logic [7:0]  ex_data;
`ifdef ALU_DIV_GUARD_EN
    logic        err_div0_q, ex_div0;
`endif

    assign opc = instr_q[OPC_MSB:OPC_LSB];
    assign rd  = instr_q[RD_MSB:RD_LSB];
    assign rs  = instr_q[RS_MSB:RS_LSB];
    assign imm = instr_q[IMM_MSB:IMM_LSB];

    // MUL high byte lands in R[rd^1] on the secondary port, same cycle as the rd write.
    cu_regfile u_regfile (
        .clk     (clk),
        .reset_n (reset_n),
        .raddr_a (rd),
        .rdata_a (rdata_rd),
        .raddr_b (rs),
        .rdata_b (rdata_rs),
        .we_a    (wb_valid_q),
        .waddr_a (wb_addr_q),
        .wdata_a (wb_data_q),
        .we_b    (mul_wr_q),
        .waddr_b (wb_addr_q ^ 2'b01),
        .wdata_b (res_hi_q)
    );

    // Writeback decision, evaluated during EXECUTE and registered into the wb_* outputs.
    always_comb begin
        ex_wr    = 1'b0;
        ex_mul   = 1'b0;
        ex_carry = 1'b0;
        ex_data  = bus.alu_result[7:0];
`ifdef ALU_DIV_GUARD_EN
        ex_div0  = 1'b0;
`endif
        if (opc >= OP_ADD && opc <= OP_ALU_LAST) begin
            ex_wr    = 1'b1;
            ex_mul   = (opc == OP_MUL);
            ex_carry = (opc == OP_ADD) || (opc == OP_SUB);
`ifdef ALU_DIV_GUARD_EN
            if (opc == OP_DIV && operand_2_q == 8'h00) begin
                ex_wr   = 1'b0;
                ex_div0 = 1'b1;
            end
`endif
        end else if (opc == OP_LDI) begin
            ex_wr   = 1'b1;
            ex_data = imm;
        end else if (opc == OP_MOV) begin
            ex_wr   = 1'b1;
            ex_data = operand_2_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StFetch;
            pc_q         <= PC_RESET;
            instr_q      <= 16'h0000;
            alu_enable_q <= 1'b0;
            alu_opcode_q <= 4'h0;
            operand_1_q  <= 8'h00;
            operand_2_q  <= 8'h00;
            res_hi_q     <= 8'h00;
            wb_valid_q   <= 1'b0;
            mul_wr_q     <= 1'b0;
            wb_addr_q    <= 2'b00;
            wb_data_q    <= 8'h00;
            flag_zero_q  <= 1'b0;
            flag_carry_q <= 1'b0;
            halted_q     <= 1'b0;
`ifdef ALU_DIV_GUARD_EN
            err_div0_q   <= 1'b0;
`endif
        end else begin
            wb_valid_q <= 1'b0;
            mul_wr_q   <= 1'b0;
            unique case (state_q)
                StFetch: begin
                    if (bus.instr_valid) begin
                        instr_q <= bus.instr_data;
                        state_q <= StDecode;
                    end
                end
                StDecode: begin
                    alu_enable_q <= 1'b1;
                    alu_opcode_q <= opc;
                    operand_1_q  <= rdata_rd;
                    operand_2_q  <= rdata_rs;
                    state_q      <= StExecute;
                end
                StExecute: begin
                    alu_enable_q <= 1'b0;
                    res_hi_q     <= bus.alu_result[15:8];
                    wb_valid_q   <= ex_wr;
                    mul_wr_q     <= ex_wr & ex_mul;
                    wb_addr_q    <= rd;
                    wb_data_q    <= ex_data;
                    if (ex_wr) flag_zero_q <= (ex_data == 8'h00);
                    if (ex_wr && ex_carry) flag_carry_q <= bus.alu_result[8];
`ifdef ALU_DIV_GUARD_EN
                    if (ex_div0) err_div0_q <= 1'b1;
`endif
                    state_q      <= StWriteback;
                end
                StWriteback: begin
                    state_q <= StFetch;
                    case (opc)
                        OP_JMP:  pc_q <= imm;
                        OP_BRZ:  pc_q <= flag_zero_q ? imm : pc_q + 8'd1;
                        OP_HALT: begin
                            halted_q <= 1'b1;
                            state_q  <= StHalt;
                        end
                        default: pc_q <= pc_q + 8'd1;
                    endcase
                end
                StHalt: state_q <= StHalt;
                default: state_q <= StFetch;
            endcase
        end
    end

    assign bus.instr_req     = (state_q == StFetch);
    assign bus.instr_addr    = pc_q;
    assign bus.alu_enable    = alu_enable_q;
    assign bus.alu_opcode    = alu_opcode_q;
    assign bus.alu_operand_1 = operand_1_q;
    assign bus.alu_operand_2 = operand_2_q;
    assign bus.wb_valid      = wb_valid_q;
    assign bus.wb_addr       = wb_addr_q;
    assign bus.wb_data       = wb_data_q;
    assign bus.flag_zero     = flag_zero_q;
    assign bus.flag_carry    = flag_carry_q;
    assign bus.halted        = halted_q;
`ifdef ALU_DIV_GUARD_EN
    assign bus.err_div0      = err_div0_q;
`else
    assign bus.err_div0      = 1'b0;
`endif
endmodule

// File: tb/tb_alu_control_unit.sv
// Self-checking bench for alu_control_unit: instruction-level model plus directed programs.
module tb_alu_control_unit;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    alu_control_unit_if bus ();

    alu_control_unit #(.PC_RESET(8'h00)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

`ifdef ALU_DIV_GUARD_EN
    localparam bit Guard = 1'b1;
`else
    localparam bit Guard = 1'b0;
`endif

    typedef struct packed {logic [1:0] a; logic [7:0] d; logic fz; logic fc;} wb_t;
    typedef struct packed {logic [3:0] op; logic [7:0] x; logic [7:0] y;} ex_t;

    logic [15:0] mem [256];
    logic [7:0]  exp_fetch [$];
    ex_t         exp_ex [$];
    wb_t         exp_wb [$];
    logic [7:0]  dut_fetch [$];
    int          dut_fetch_cyc [$];
    ex_t         dut_ex [$];
    wb_t         dut_wb [$];
    bit          m_err;
    bit          cmp_en = 1'b0;
    int          cyc_cnt = 0;
    int          n_chk = 0;
    int          n_pass = 0;

    // Environment ALU: plain arithmetic on the driven opcode/operands.
    function automatic logic [15:0] alu_fn(input logic [3:0] op, input logic [7:0] a,
                                           input logic [7:0] b);
        case (op)
            4'h1: return {8'h00, a} + {8'h00, b};
            4'h2: return {8'h00, a} - {8'h00, b};
            4'h3: return {8'h00, a} * {8'h00, b};
            4'h4: return (b == 8'h00) ? 16'hFFFF : {8'h00, a / b};
            4'h5: return {8'h00, a & b};
            4'h6: return {8'h00, a | b};
            4'h7: return {8'h00, a ^ b};
            4'h8: return {8'h00, ~a};
            4'h9: return {7'h00, a, 1'b0};
            4'hA: return {8'h00, a >> 1};
            default: return 16'h0000;
        endcase
    endfunction

    assign bus.instr_data = mem[bus.instr_addr];
    assign bus.alu_result = alu_fn(bus.alu_opcode, bus.alu_operand_1, bus.alu_operand_2);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        $display("FAIL %s: got no event, expected one", name);
    endtask

    // Instruction-level reference: executes the program architecturally from reset.
    task automatic model_run(input int max_instr);
        logic [7:0]  r [4];
        logic [7:0]  pc, d, a, b;
        logic [15:0] w, res;
        logic [3:0]  op;
        logic [1:0]  rd, rs;
        bit          fz, fc, wr;
        wb_t         e;
        ex_t         x;
        for (int i = 0; i < 4; i++) r[i] = 8'h00;
        pc = 8'h00; fz = 1'b0; fc = 1'b0; m_err = 1'b0;
        for (int n = 0; n < max_instr; n++) begin
            w  = mem[pc];
            op = w[15:12]; rd = w[11:10]; rs = w[9:8];
            a  = r[rd]; b = r[rs];
            exp_fetch.push_back(pc);
            x.op = op; x.x = a; x.y = b;
            exp_ex.push_back(x);
            res = alu_fn(op, a, b);
            wr = 1'b0; d = res[7:0];
            if (op >= 4'h1 && op <= 4'hA) begin
                if (Guard && op == 4'h4 && b == 8'h00) m_err = 1'b1;
                else begin
                    wr = 1'b1;
                    if (op == 4'h1 || op == 4'h2) fc = res[8];
                end
            end else if (op == 4'hB) begin
                wr = 1'b1; d = w[7:0];
            end else if (op == 4'hC) begin
                wr = 1'b1; d = b;
            end
            if (wr) begin
                fz = (d == 8'h00);
                e.a = rd; e.d = d; e.fz = fz; e.fc = fc;
                exp_wb.push_back(e);
                r[rd] = d;
                if (op == 4'h3) r[rd ^ 2'b01] = res[15:8];
            end
            if (op == 4'hF) break;
            else if (op == 4'hD) pc = w[7:0];
            else if (op == 4'hE) pc = fz ? w[7:0] : pc + 8'd1;
            else pc = pc + 8'd1;
        end
    endtask

    ex_t c_ex;
    wb_t c_wb;
    always @(negedge clk) begin
        cyc_cnt++;
        if (cmp_en) begin
            if (bus.instr_req && bus.instr_valid) begin
                dut_fetch.push_back(bus.instr_addr);
                dut_fetch_cyc.push_back(cyc_cnt);
                if (exp_fetch.size() == 0) fail_now("fetch_unexpected");
                else check("fetch_addr", bus.instr_addr, exp_fetch.pop_front());
            end
            if (bus.alu_enable) begin
                c_ex.op = bus.alu_opcode; c_ex.x = bus.alu_operand_1; c_ex.y = bus.alu_operand_2;
                dut_ex.push_back(c_ex);
                if (exp_ex.size() == 0) fail_now("exec_unexpected");
                else check("exec_op_operands", c_ex, exp_ex.pop_front());
            end
            if (bus.wb_valid) begin
                c_wb.a = bus.wb_addr; c_wb.d = bus.wb_data;
                c_wb.fz = bus.flag_zero; c_wb.fc = bus.flag_carry;
                dut_wb.push_back(c_wb);
                if (exp_wb.size() == 0) fail_now("wb_unexpected");
                else check("wb_addr_data_flags", c_wb, exp_wb.pop_front());
            end
        end
    end

    task automatic load_mem(input logic [15:0] prog [], input logic [7:0] base);
        foreach (prog[i]) mem[base + 8'(i)] = prog[i];
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 16'hF000;
    endtask

    task automatic run_prog(input string name, input bit stall);
        int cyc;
        reset_n = 1'b0;
        bus.instr_valid = 1'b1;
        exp_fetch.delete(); exp_ex.delete(); exp_wb.delete();
        dut_fetch.delete(); dut_fetch_cyc.delete(); dut_ex.delete(); dut_wb.delete();
        model_run(64);
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        cmp_en = 1'b1;
        cyc = 0;
        while (!bus.halted && cyc < 400) begin
            @(posedge clk);
            #2 bus.instr_valid = stall ? (cyc % 3 != 2) : 1'b1;
            cyc++;
        end
        if (!bus.halted) fail_now({name, "_halt_timeout"});
        repeat (4) begin
            @(negedge clk);
            check({name, "_halt_req"}, bus.instr_req, 1'b0);
            check({name, "_halt_wb"}, bus.wb_valid, 1'b0);
        end
        check({name, "_fetch_left"}, exp_fetch.size(), 0);
        check({name, "_exec_left"}, exp_ex.size(), 0);
        check({name, "_wb_left"}, exp_wb.size(), 0);
        check({name, "_err_div0"}, bus.err_div0, m_err);
        cmp_en = 1'b0;
    endtask

    task automatic lit_wb(input string name, input int idx, input logic [1:0] a,
                          input logic [7:0] d, input logic fz, input logic fc);
        wb_t e;
        e.a = a; e.d = d; e.fz = fz; e.fc = fc;
        if (dut_wb.size() <= idx) fail_now(name);
        else check(name, dut_wb[idx], e);
    endtask

    initial begin
        logic [15:0] p1 [] = '{16'hB005, 16'hB403, 16'h1100, 16'hB8FF, 16'hBC01, 16'h1B00,
                               16'hB010, 16'hB420, 16'h3100, 16'hC900, 16'hCC00, 16'hE040};
        logic [15:0] p3 [] = '{16'hB007, 16'hB400, 16'h4100, 16'hC800, 16'hF000};
        logic [15:0] p4 [] = '{16'hB055, 16'h1000, 16'hF000};
        ex_t mx;
        bit  found;
        bus.instr_valid = 1'b1;

        // Load/add, carry, MUL, MOV readback, BRZ taken to 0x40 then HALT.
        clear_mem();
        load_mem(p1, 8'h00);
        run_prog("p1", 1'b0);
        lit_wb("p1_add_08", 2, 2'd0, 8'h08, 1'b0, 1'b0);
        lit_wb("p1_add_wrap", 5, 2'd2, 8'h00, 1'b1, 1'b1);
        lit_wb("p1_mul_lo", 8, 2'd0, 8'h00, 1'b1, 1'b1);
        lit_wb("p1_mov_r1_hi", 9, 2'd2, 8'h02, 1'b0, 1'b1);
        mx.op = 4'h3; mx.x = 8'h10; mx.y = 8'h20;
        if (dut_ex.size() <= 8) fail_now("p1_mul_operands");
        else check("p1_mul_operands", dut_ex[8], mx);
        if (dut_fetch.size() <= 12) fail_now("p1_brz_target");
        else check("p1_brz_target", dut_fetch[12], 8'h40);
        if (dut_fetch_cyc.size() < 2) fail_now("p1_min_latency");
        else check("p1_min_latency", dut_fetch_cyc[1] - dut_fetch_cyc[0], 4);

        // BRZ not taken, JMP 0xFF, NOP wraps PC to 0x00, BRZ taken to HALT; with stalls.
        clear_mem();
        mem[8'h00] = 16'hE010; mem[8'h01] = 16'hB000; mem[8'h02] = 16'hD0FF;
        mem[8'hFF] = 16'h0000;
        run_prog("p2", 1'b1);
        if (dut_fetch.size() <= 5) fail_now("p2_wrap");
        else begin
            check("p2_brz_not_taken", dut_fetch[1], 8'h01);
            check("p2_wrap", dut_fetch[4], 8'h00);
            check("p2_brz_taken", dut_fetch[5], 8'h10);
        end

        // DIV by zero, then MOV exposes R0.
        clear_mem();
        load_mem(p3, 8'h00);
        run_prog("p3", 1'b1);
`ifdef ALU_DIV_GUARD_EN
        check("p3_wb_count", dut_wb.size(), 3);
        lit_wb("p3_r0_kept", 2, 2'd2, 8'h07, 1'b0, 1'b0);
        check("p3_err_div0", bus.err_div0, 1'b1);
`else
        check("p3_wb_count", dut_wb.size(), 4);
        lit_wb("p3_div_written", 2, 2'd0, 8'hFF, 1'b0, 1'b0);
        check("p3_err_div0", bus.err_div0, 1'b0);
`endif

        // Reset values, fetch stall, reset during EXECUTE.
        clear_mem();
        load_mem(p4, 8'h00);
        reset_n = 1'b0;
        bus.instr_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_instr_req", bus.instr_req, 1'b1);
        check("rst_instr_addr", bus.instr_addr, 8'h00);
        check("rst_alu_enable", bus.alu_enable, 1'b0);
        check("rst_alu_opcode", bus.alu_opcode, 4'h0);
        check("rst_alu_operands", {bus.alu_operand_1, bus.alu_operand_2}, 16'h0000);
        check("rst_wb", {bus.wb_valid, bus.wb_addr, bus.wb_data}, 11'h000);
        check("rst_flags", {bus.flag_zero, bus.flag_carry, bus.err_div0, bus.halted}, 4'h0);
        @(posedge clk);
        #2 reset_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("stall_addr", bus.instr_addr, 8'h00);
            check("stall_req", bus.instr_req, 1'b1);
            check("stall_wb", bus.wb_valid, 1'b0);
        end
        @(posedge clk);
        #2 bus.instr_valid = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (bus.alu_enable && bus.alu_opcode == 4'h1) found = 1'b1;
        end
        if (!found) fail_now("p4_add_execute");
        else begin
            check("p4_add_operands", {bus.alu_operand_1, bus.alu_operand_2}, 16'h5555);
            reset_n = 1'b0;
            #1;
            check("p4_rst_alu_enable", bus.alu_enable, 1'b0);
            check("p4_rst_addr", bus.instr_addr, 8'h00);
            check("p4_rst_req", bus.instr_req, 1'b1);
            repeat (2) begin
                @(negedge clk);
                check("p4_rst_no_wb", bus.wb_valid, 1'b0);
            end
            @(posedge clk);
            #2 reset_n = 1'b1;
            dut_wb.delete();
            @(negedge clk);
            check("p4_restart_addr", bus.instr_addr, 8'h00);
            for (int i = 0; i < 60 && !bus.halted; i++) begin
                if (bus.wb_valid) begin
                    c_wb.a = bus.wb_addr; c_wb.d = bus.wb_data;
                    c_wb.fz = bus.flag_zero; c_wb.fc = bus.flag_carry;
                    dut_wb.push_back(c_wb);
                end
                @(negedge clk);
            end
            check("p4_halted", bus.halted, 1'b1);
            check("p4_wb_count", dut_wb.size(), 2);
            lit_wb("p4_ldi_again", 0, 2'd0, 8'h55, 1'b0, 1'b0);
            lit_wb("p4_add_aa", 1, 2'd0, 8'hAA, 1'b0, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
